// File: rtl/ppu_oam_scanner.sv
// rtl/ppu_oam_scanner.sv - OAM scan engine selecting objects that overlap the current scanline
module ppu_oam_scanner #(
  parameter int          OBJ_COUNT = 40,
  parameter int          MAX_HITS  = 10,
  parameter logic [15:0] OAM_BASE  = 16'hFE00,
  localparam int HCW = $clog2(MAX_HITS + 1),
  localparam int SW  = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1,
  localparam int IW  = (OBJ_COUNT > 1) ? $clog2(OBJ_COUNT) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [7:0]     ly,
  input  logic           tall,
  output logic           mem_rd,
  output logic [15:0]    mem_addr,
  input  logic [7:0]     mem_data,
  output logic           busy,
  output logic           done,
  output logic [HCW-1:0] hit_count,
  output logic           overflow,
  input  logic [SW-1:0]  sel,
  output logic           entry_valid,
  output logic [7:0]     entry_x,
  output logic [IW-1:0]  entry_idx,
  output logic [3:0]     entry_row
);

  // Step counter covers two issue slots per object plus the drain step.
  localparam int STW       = $clog2(2 * OBJ_COUNT + 1);
  localparam int LAST_STEP = 2 * OBJ_COUNT;

  if (int'(OAM_BASE) + 4 * OBJ_COUNT - 3 > 65535) begin : g_bad_base
    $error("ppu_oam_scanner: OAM address range exceeds 16 bits");
  end
  if (MAX_HITS < 1) begin : g_bad_hits
    $error("ppu_oam_scanner: MAX_HITS must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [STW-1:0] step;
  logic [7:0]     ly_l;
  logic           tall_l;
  logic           pend_hit;
  logic [3:0]     pend_row;
  logic [IW-1:0]  pend_idx;

  logic [7:0]     buf_x   [MAX_HITS];
  logic [IW-1:0]  buf_idx [MAX_HITS];
  logic [3:0]     buf_row [MAX_HITS];

  logic           drain;
  logic [IW-1:0]  obj;
  logic [8:0]     line9, y9, end9, diff9;
  logic           in_range;
  logic           commit;

  assign drain    = (step == STW'(LAST_STEP));
  assign obj      = IW'(step >> 1);
  assign busy     = (state == ST_SCAN);
  assign done     = (state == ST_DONE);
  assign mem_rd   = busy && !drain;
  assign mem_addr = OAM_BASE + (16'(step >> 1) << 2) + 16'(step[0]);

  // In slot B the returned byte is Y; the line is in range when Y <= ly+16 < Y+height.
  assign line9    = {1'b0, ly_l} + 9'd16;
  assign y9       = {1'b0, mem_data};
  assign end9     = y9 + (tall_l ? 9'd16 : 9'd8);
  assign diff9    = line9 - y9;
  assign in_range = (line9 >= y9) && (line9 < end9);

  // Slot A after a slot B (or the drain step) carries the X byte of the previous object.
  assign commit   = busy && !step[0] && (step != '0) && pend_hit;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_SCAN;
      ST_SCAN: if (drain) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Scan datapath: step sequencing, range evaluation, result commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step      <= '0;
      ly_l      <= '0;
      tall_l    <= 1'b0;
      pend_hit  <= 1'b0;
      pend_row  <= '0;
      pend_idx  <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < MAX_HITS; i++) begin
        buf_x[i]   <= '0;
        buf_idx[i] <= '0;
        buf_row[i] <= '0;
      end
    end else if (abort) begin
      step      <= '0;
      pend_hit  <= 1'b0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else if (state == ST_IDLE) begin
      step     <= '0;
      pend_hit <= 1'b0;
      if (start) begin
        ly_l      <= ly;
        tall_l    <= tall;
        hit_count <= '0;
        overflow  <= 1'b0;
      end
    end else if (state == ST_SCAN) begin
      step <= drain ? '0 : step + 1'b1;
      if (step[0]) begin
        pend_hit <= in_range;
        pend_row <= diff9[3:0];
        pend_idx <= obj;
      end else if (commit) begin
        pend_hit <= 1'b0;
        if (hit_count < HCW'(MAX_HITS)) begin
          buf_x[SW'(hit_count)]   <= mem_data;
          buf_idx[SW'(hit_count)] <= pend_idx;
          buf_row[SW'(hit_count)] <= pend_row;
          hit_count               <= hit_count + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end else begin
      step <= '0;
    end
  end

  // Random-access result port; invalid slots read as zero.
  always_comb begin
    entry_valid = (32'(sel) < 32'(hit_count));
    entry_x     = '0;
    entry_idx   = '0;
    entry_row   = '0;
    if (entry_valid) begin
      entry_x   = buf_x[sel];
      entry_idx = buf_idx[sel];
      entry_row = buf_row[sel];
    end
  end

endmodule

// File: tb/tb_ppu_oam_scanner.sv
// tb/tb_ppu_oam_scanner.sv - directed self-checking bench for ppu_oam_scanner
module tb_ppu_oam_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tall = 1'b0;
  logic [7:0]  ly = 8'd0;
  logic [7:0]  mem_data = 8'd0;
  logic [3:0]  sel = 4'd0;
  logic [1:0]  sel4 = 2'd0;

  logic        mem_rd, busy, done, overflow, entry_valid;
  logic [15:0] mem_addr;
  logic [3:0]  hit_count, entry_row;
  logic [7:0]  entry_x;
  logic [5:0]  entry_idx;

  logic        mem_rd4, busy4, done4, overflow4, entry_valid4;
  logic [15:0] mem_addr4;
  logic [2:0]  hit_count4;
  logic [3:0]  entry_row4;
  logic [7:0]  entry_x4;
  logic [5:0]  entry_idx4;

  logic [7:0]  oam [256];
  int checks = 0;
  int errors = 0;
  int rd_total = 0;
  int rd_mark = 0;
  int addr_bad = 0;

  ppu_oam_scanner u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ly(ly), .tall(tall),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .hit_count(hit_count), .overflow(overflow),
    .sel(sel), .entry_valid(entry_valid), .entry_x(entry_x),
    .entry_idx(entry_idx), .entry_row(entry_row)
  );

  ppu_oam_scanner #(.MAX_HITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ly(ly), .tall(tall),
    .mem_rd(mem_rd4), .mem_addr(mem_addr4), .mem_data(mem_data),
    .busy(busy4), .done(done4), .hit_count(hit_count4), .overflow(overflow4),
    .sel(sel4), .entry_valid(entry_valid4), .entry_x(entry_x4),
    .entry_idx(entry_idx4), .entry_row(entry_row4)
  );

  always #5 clk = ~clk;

  // OAM memory model: data one cycle after the read, read order checked against FE00,FE01,FE04,...
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= oam[mem_addr[7:0]];
      if (mem_addr !== 16'hFE00 + 16'(((rd_total - rd_mark) / 2) * 4 + (rd_total - rd_mark) % 2))
        addr_bad <= addr_bad + 1;
      rd_total <= rd_total + 1;
    end
  end

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task clear_oam();
    for (int i = 0; i < 256; i++) oam[i] = 8'd0;
  endtask

  task set_obj(input int n, input int y, input int x);
    oam[4*n]   = 8'(y);
    oam[4*n+1] = 8'(x);
  endtask

  // Returns at the negedge inside cycle 1 (cycle 0 is the start sample edge).
  task start_scan(input logic [7:0] l, input logic t);
    @(negedge clk);
    ly = l;
    tall = t;
    start = 1'b1;
    rd_mark = rd_total;
    @(negedge clk);
    start = 1'b0;
  endtask

  task wait_done(output int cyc, output logic busy81, output logic rd81);
    cyc = 1;
    busy81 = 1'b0;
    rd81 = 1'b1;
    while (!done && cyc < 300) begin
      if (cyc == 81) begin
        busy81 = busy;
        rd81 = mem_rd;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  int   cyc, cnt;
  logic b81, r81;
  int   exp_idx [3] = '{2, 7, 39};
  int   exp_x   [3] = '{10, 20, 30};

  initial begin
    clear_oam();
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_mem_addr", mem_addr, 16'hFE00);
    check("rst_entry_valid", entry_valid, 0);
    rst = 1'b1;

    // Empty line
    start_scan(8'd40, 1'b0);
    check("empty_busy_c1", busy, 1);
    check("empty_rd_c1", mem_rd, 1);
    check("empty_addr_c1", mem_addr, 16'hFE00);
    wait_done(cyc, b81, r81);
    check("empty_done_cycle", cyc, 82);
    check("empty_busy_drain", b81, 1);
    check("empty_rd_drain", r81, 0);
    check("empty_reads", rd_total - rd_mark, 80);
    check("empty_addr_seq", addr_bad, 0);
    check("empty_hits", hit_count, 0);
    check("empty_overflow", overflow, 0);
    @(negedge clk);
    check("empty_done_pulse", done, 0);
    check("empty_busy_after", busy, 0);

    // Three hits
    clear_oam();
    set_obj(2, 56, 10);
    set_obj(7, 56, 20);
    set_obj(39, 56, 30);
    start_scan(8'd40, 1'b0);
    wait_done(cyc, b81, r81);
    check("three_done_cycle", cyc, 82);
    check("three_hits", hit_count, 3);
    for (int i = 0; i < 3; i++) begin
      sel = 4'(i);
      #1;
      check("three_valid", entry_valid, 1);
      check("three_idx", entry_idx, exp_idx[i]);
      check("three_x", entry_x, exp_x[i]);
      check("three_row", entry_row, 0);
    end
    sel = 4'd3;
    #1;
    check("three_sel3_valid", entry_valid, 0);
    check("three_sel3_x", entry_x, 0);
    check("three_sel3_idx", entry_idx, 0);

    // Tall mode
    clear_oam();
    set_obj(5, 40, 77);
    start_scan(8'd34, 1'b0);
    wait_done(cyc, b81, r81);
    check("short_hits", hit_count, 0);
    start_scan(8'd34, 1'b1);
    wait_done(cyc, b81, r81);
    check("tall_hits", hit_count, 1);
    sel = 4'd0;
    #1;
    check("tall_idx", entry_idx, 5);
    check("tall_row", entry_row, 10);
    check("tall_x", entry_x, 77);

    // Overflow
    clear_oam();
    for (int i = 0; i < 12; i++) set_obj(i, 20, 100 + i);
    start_scan(8'd10, 1'b0);
    wait_done(cyc, b81, r81);
    check("ovf_done_cycle", cyc, 82);
    check("ovf_hits", hit_count, 10);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 10; i++) begin
      sel = 4'(i);
      #1;
      check("ovf_idx", entry_idx, i);
      check("ovf_x", entry_x, 100 + i);
    end
    check("ovf_row", entry_row, 6);
    check("ovf4_hits", hit_count4, 4);
    check("ovf4_flag", overflow4, 1);
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      #1;
      check("ovf4_idx", entry_idx4, i);
    end

    // Abort at cycle 30
    start_scan(8'd10, 1'b0);
    repeat (29) @(negedge clk);
    check("abort_busy_c30", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_c31", busy, 0);
    check("abort_done_c31", done, 0);
    check("abort_hits", hit_count, 0);
    check("abort4_hits", hit_count4, 0);
    check("abort4_overflow", overflow4, 0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);

    // Start and abort together
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("startabort_busy", busy, 0);
    cnt = 0;
    repeat (90) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("startabort_idle", cnt, 0);

    start_scan(8'd10, 1'b0);
    wait_done(cyc, b81, r81);
    check("restart_done_cycle", cyc, 82);
    check("restart_hits", hit_count, 10);

    // Async reset at cycle 15
    start_scan(8'd10, 1'b0);
    repeat (14) @(negedge clk);
    check("rstmid_hits_c15", hit_count, 6);
    check("rstmid4_ovf_c15", overflow4, 1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_mem_rd", mem_rd, 0);
    check("rstmid_hits", hit_count, 0);
    check("rstmid_addr", mem_addr, 16'hFE00);
    check("rstmid_done", done, 0);
    check("rstmid4_overflow", overflow4, 0);
    check("rstmid_valid", entry_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    clear_oam();
    start_scan(8'd40, 1'b0);
    wait_done(cyc, b81, r81);
    check("postrst_done_cycle", cyc, 82);
    check("postrst_reads", rd_total - rd_mark, 80);
    check("postrst_addr_seq", addr_bad, 0);
    check("postrst_hits", hit_count, 0);
    check("postrst_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_oam_scanner.md
# ppu_oam_scanner

Parametrised OAM-scan engine for the PPU's mode-2 phase. On each `start` it walks the object attribute table through the PPU memory port and selects the objects that overlap the current scanline, up to a configurable limit, in OAM order. It stores each object's X, index and row-within-object for the draw stage. It replaces the fixed 40/10 inline scan logic with a standalone block that has configurable depth, an overflow flag, abort and a random-access result port.

## Interface
- `OBJ_COUNT`, 40: objects in OAM, 4 bytes each (Y, X, tile, attr).
- `MAX_HITS`, 10: result buffer depth, ≥1.
- `OAM_BASE`, 16'hFE00: byte address of object 0.
- `clk` input 1: single clock domain.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle request to begin a scan; samples `ly` and `tall`.
- `abort` input 1: synchronous cancel, returns to IDLE.
- `ly` input 8: current scanline.
- `tall` input 1: 0 = 8-line objects, 1 = 16-line objects (LCDC[2]).
- `mem_rd` output 1: read strobe.
- `mem_addr` output 16: OAM byte address.
- `mem_data` input 8: read data, valid exactly 1 cycle after the `mem_rd` cycle.
- `busy` output 1: high in SCAN.
- `done` output 1: one-cycle pulse at scan completion.
- `hit_count` output $clog2(MAX_HITS+1): entries stored.
- `overflow` output 1: more than MAX_HITS objects were in range.
- `sel` input $clog2(MAX_HITS): result read index.
- `entry_valid` output 1: `sel < hit_count`.
- `entry_x` output 8: stored X byte.
- `entry_idx` output $clog2(OBJ_COUNT): OAM object number.
- `entry_row` output 4: `ly_l + 16 - Y`, the row within the object.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE → SCAN on `start` when `abort` = 0:
  - latch `ly_l` = `ly` and `tall_l` = `tall`;
  - clear `hit_count` and `overflow`;
  - object counter n = 0.
- SCAN, per object n, two issue slots:
  - Slot A issues `mem_addr` = OAM_BASE + 4n (the Y byte).
  - Slot B issues OAM_BASE + 4n + 1 (the X byte) and evaluates the Y data returned from slot A.
  - The next slot A receives the X data and commits the entry if the object was in range.
  - Issue is fully pipelined: `mem_rd` stays high every SCAN cycle.
- In-range test, in 9-bit arithmetic: (ly_l + 16 ≥ Y) and (ly_l + 16 < Y + (tall_l ? 16 : 8)).
- Commit:
  - if `hit_count` < MAX_HITS: write {X, n, row} to `hit_count`, then increment it;
  - else set `overflow` and drop the entry.
- Slot B of the last object is followed by one drain cycle (`mem_rd` = 0) that commits the final entry, then → DONE.
- DONE lasts one cycle (`done` = 1), then → IDLE. Results persist until the next `start`.
- `start` during SCAN or DONE is ignored.
- `abort` in any state → IDLE next cycle:
  - `hit_count` and `overflow` are cleared and `done` is not pulsed;
  - `abort` and `start` in the same cycle: `abort` wins.
- The result port is combinational from `sel` and the buffer:
  - `entry_valid` = 0 drives `entry_x`, `entry_idx` and `entry_row` to 0;
  - results are readable during SCAN and show partially filled entries.
- Ordering: entries are stored in ascending OAM index; the lower index wins on overflow.

## Timing
- Reset values: state IDLE; `mem_rd`, `busy`, `done`, `hit_count`, `overflow` are 0; `mem_addr` = OAM_BASE; buffer contents are 0.
- Reset asserted mid-scan aborts immediately. No `done` is produced.
- Cycle 0 is the `start` sample edge. The first `mem_rd` is high in cycle 1 with addr OAM_BASE.
- Scan length is 2·OBJ_COUNT issue cycles plus 1 drain cycle. `done` is high in cycle 2·OBJ_COUNT + 2, which is cycle 82 for the defaults.
- `busy` is high from cycle 1 through the drain cycle inclusive.
- `hit_count` updates on the edge ending the commit slot. The result port reflects it the same cycle.
- Object Y = 0 or Y ≥ 160 is never in range for ly < 144. This follows from the arithmetic above; there is no special case.
- `mem_addr` max = OAM_BASE + 4·OBJ_COUNT − 3. It must not exceed 16 bits (elaboration assertion).

## Test plan
- Empty line: all Y = 0, ly = 40, start:
  - 80 reads at FE00, FE01, FE04, …, FE9D;
  - `done` at cycle 82;
  - `hit_count` = 0, `overflow` = 0.
- Three hits: objects 2, 7, 39 at Y = 56, X = 10/20/30; ly = 40, tall = 0:
  - `hit_count` = 3;
  - sel 0..2 give idx 2/7/39, X 10/20/30, row 0;
  - sel 3 gives `entry_valid` = 0.
- Tall mode: object 5 Y = 40, ly = 34:
  - tall = 0 gives no hit;
  - tall = 1 gives a hit with row 10.
- Overflow: 12 objects (0..11) at Y = 20, ly = 10:
  - `hit_count` = 10, idx 0..9, `overflow` = 1.
  - With MAX_HITS = 4 the bench expects idx 0..3.
- Abort and restart:
  - `abort` at cycle 30 gives IDLE at cycle 31 and `hit_count` = 0, with no `done`;
  - `start` and `abort` together leave the block in IDLE;
  - a subsequent start completes normally.
- Async reset asserted at cycle 15 of a scan:
  - outputs are at reset values before the next clock edge;
  - `start` after release behaves as in the first scenario.
